debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank
//   Bank of independent push-button debouncers with press/release edge pulses
//   and per-channel auto-repeat while a button is held.
//
// Parameters
//   NUM_CH        number of button channels (1..32)
//   STABLE_CYCLES consecutive synchronized samples needed to accept a new level
//   REPEAT_DELAY  cycles from the press pulse to the first repeat pulse
//   REPEAT_PERIOD cycles between subsequent repeat pulses
//
// Ports
//   src_clk       sole clock, rising edge
//   src_rst       asynchronous active-high reset
//   button        raw asynchronous button levels (active-high)
//   repeat_en     per-channel auto-repeat enable (src_clk domain)
//   deb_level     debounced, registered level
//   press_pulse   one-cycle pulse, coincident with the first cycle deb_level reads 1
//   release_pulse one-cycle pulse, coincident with the first cycle deb_level reads 0
//   repeat_pulse  one-cycle auto-repeat pulse while held and enabled
module debounce_bank #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic              src_clk,
    input  logic              src_rst,
    input  logic [NUM_CH-1:0] button,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] deb_level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] repeat_pulse
);

    localparam int unsigned SCW  = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HCW  = $clog2(HMAX) + 1;

    localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [HCW-1:0] DLY_LAST  = HCW'(REPEAT_DELAY - 1);
    localparam logic [HCW-1:0] PER_LAST  = HCW'(REPEAT_PERIOD - 1);

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] deb_q, deb_d;
    logic [NUM_CH-1:0] press_q, press_d;
    logic [NUM_CH-1:0] release_q, release_d;
    logic [NUM_CH-1:0] repeat_q, repeat_d;
    // 0: waiting out the initial delay, 1: waiting out a repeat period
    logic [NUM_CH-1:0] phase_q, phase_d;
    logic [SCW-1:0]    stab_q [NUM_CH];
    logic [SCW-1:0]    stab_d [NUM_CH];
    logic [HCW-1:0]    hold_q [NUM_CH];
    logic [HCW-1:0]    hold_d [NUM_CH];

    always_comb begin
        logic accept;
        accept    = 1'b0;
        deb_d     = deb_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        phase_d   = phase_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            accept = 1'b0;

            // Qualification: any sample matching the accepted level restarts it.
            if (sync2_q[ch] == deb_q[ch]) begin
                stab_d[ch] = '0;
            end else if (stab_q[ch] == STAB_LAST) begin
                stab_d[ch]    = '0;
                deb_d[ch]     = sync2_q[ch];
                press_d[ch]   = sync2_q[ch];
                release_d[ch] = ~sync2_q[ch];
                accept        = 1'b1;
            end else begin
                stab_d[ch] = stab_q[ch] + 1'b1;
            end

            // Hold timing restarts on the accepting edge, so a repeat can never
            // land on a press or release cycle; the hold counter is zero during
            // the press cycle and during the first cycle repeat_en reads high.
            if (!deb_q[ch] || !repeat_en[ch] || accept) begin
                hold_d[ch]  = '0;
                phase_d[ch] = 1'b0;
            end else if (hold_q[ch] == (phase_q[ch] ? PER_LAST : DLY_LAST)) begin
                hold_d[ch]   = '0;
                phase_d[ch]  = 1'b1;
                repeat_d[ch] = 1'b1;
            end else begin
                hold_d[ch] = hold_q[ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            phase_q   <= '0;
            stab_q    <= '{default: '0};
            hold_q    <= '{default: '0};
        end else begin
            // Two-flop synchronizer; nothing else looks at button.
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            phase_q   <= phase_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
        end
    end

    assign deb_level     = deb_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule
